e203_fpu_ctrl: RTL
==================

Name: e203_fpu_ctrl

Overview:
- Issue/sequencing controller between the FPU decode stage and the shared FPU datapath.
- Accepts one decoded float op at a time and checks read-after-write and write-after-write hazards against a 32-entry FP register scoreboard.
- Resolves the dynamic rounding mode, then runs request → response → writeback handshakes.
- Tracks FLW loads in flight in the LSU and accumulates fflags for the CSR unit.

Parameters:
- ITAG_W, 1, width of the instruction tag carried through to writeback.
- NFREG, 32, number of FP registers tracked by the scoreboard; the index width is 5.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high
- i_valid  in  1  decoded float op valid
- i_ready  out  1  op accepted this cycle
- i_ftype  in  5  float op type (0..29; 31 = none)
- i_rm  in  3  instruction rounding-mode field
- i_frs1en/i_frs2en/i_frs3en/i_frdwen  in  1 each  operand/destination enables
- i_frs1idx/i_frs2idx/i_frs3idx/i_frdidx  in  5 each  register indices
- i_rs1fpu/i_rs2fpu/i_rs3fpu/i_rdfpu  in  1 each  1 = FP register file, 0 = integer register file
- i_itag  in  ITAG_W  instruction tag
- csr_frm  in  3  dynamic rounding mode from fcsr
- fpu_req_valid  out  1  request to the datapath
- fpu_req_ready  in  1  datapath accepts the request
- fpu_req_ftype  out  5  latched op type
- fpu_req_rm  out  3  resolved rounding mode
- fpu_rsp_valid  in  1  datapath result ready
- fpu_rsp_ready  out  1  controller takes the result
- fpu_rsp_fflags  in  5  exception flags of the result
- wbck_valid  out  1  writeback request
- wbck_ready  in  1  writeback granted
- wbck_rdfpu  out  1  destination is the FP register file
- wbck_rdwen  out  1  destination write enable
- wbck_rdidx  out  5  destination index
- wbck_itag  out  ITAG_W  tag
- wbck_illegal  out  1  illegal rounding mode; no register write
- ld_set_valid  in  1  LSU issued an FLW
- ld_set_idx  in  5  destination of that FLW
- ld_clr_valid  in  1  FLW data written back
- ld_clr_idx  in  5  index of that written-back FLW
- sb_pend  out  32  scoreboard, for the LSU's own hazard checks
- fflags_acc  out  5  sticky accumulated fflags
- fflags_clr  in  1  CSR write clears the accumulator
- busy  out  1  state != IDLE

Behaviour:
- Reset: state = IDLE; sb_pend = 0; fflags_acc = 0; all valid/ready outputs = 0; latched fields = 0.
- Hazard (combinational): the OR of all of the following.
  - For each n in {1, 2, 3}: frs<n>en & rs<n>fpu & sb_pend[frs<n>idx].
  - WAW: frdwen & rdfpu & sb_pend[frdidx].
- Rounding-mode resolution:
  - rm_eff = (i_rm == 3'b111) ? csr_frm : i_rm.
  - Illegal when rm_eff is one of 101, 110, 111.
- i_ready = (state == IDLE) & ~hazard. On acceptance, latch ftype, rm_eff, rd fields, itag and the illegal flag.
- FSM transitions:
  - IDLE → WB if the latched op is illegal (no datapath request is made).
  - IDLE → REQ otherwise.
  - REQ: fpu_req_valid = 1; on fpu_req_ready → RSP. Combinational same-cycle ready is allowed; minimum one cycle in REQ.
  - RSP: fpu_rsp_ready = 1; on fpu_rsp_valid capture fflags → WB.
  - WB: wbck_valid = 1 with wbck_rdwen = frdwen & ~illegal; on wbck_ready → IDLE.
- Minimum latency from acceptance to wbck_valid:
  - Normal op: 2 cycles plus datapath latency.
  - Illegal op: 1 cycle.
- Scoreboard:
  - Set bit frdidx on acceptance when frdwen & rdfpu & ~illegal.
  - Clear it on the WB handshake.
  - ld_set sets bit ld_set_idx; ld_clr clears bit ld_clr_idx.
  - Update order within a cycle: all clears apply first, then all sets. Same index set and cleared in one cycle → bit = 1.
  - Bits are independent; several loads may be pending at once.
- fflags:
  - On the RSP handshake: fflags_acc <= (fflags_clr ? 0 : fflags_acc) | fpu_rsp_fflags.
  - fflags_clr alone → 0.
  - Illegal ops contribute no flags.
- Outputs hold stable while valid is high and ready is low; the controller never drops valid without a handshake.
- Synchronous reset in any state:
  - Returns to IDLE; the in-flight op is abandoned and no wbck is issued.
  - Scoreboard and fflags are cleared.
  - The next accepted op starts cleanly.
- csr_frm is sampled only at acceptance; later changes do not affect a latched op.

Test Plan:
- FADD, rm = 000, frd = 5, fpu_req_ready = 1, rsp after 3 cycles with fflags = 00001 → req_rm = 000; sb_pend[5] = 1 until WB handshake; fflags_acc = 00001; wbck_rdidx = 5, rdfpu = 1.
- Op A writes f3 and is in RSP; op B reads f3 → i_ready = 0 until A's WB handshake; B accepted the cycle after (state IDLE).
- rm = 111 with csr_frm = 010 → req_rm = 010. rm = 111 with csr_frm = 101 → no fpu_req_valid; wbck_valid next cycle with wbck_illegal = 1, wbck_rdwen = 0; sb_pend unchanged.
- FEQ (rdfpu = 0, rd = x7) → no scoreboard bit set; wbck_rdfpu = 0, rdidx = 7.
- ld_set idx 9, then op reading f9 → stalled. ld_clr idx 9 with ld_set idx 9 in the same cycle → bit stays 1. Clear only → stall released the next cycle.
- fflags_acc = 00100; fflags_clr and rsp fflags 10000 in the same cycle → 10000.
- Reset asserted in RSP → busy = 0, sb_pend = 0, no wbck_valid; new op completes normally.
- wbck_ready held low 4 cycles → wbck_valid and all wbck fields stable throughout.

Source files
------------

// File: rtl/e203_fpu_ctrl.sv
// e203_fpu_ctrl
// Issue and sequencing controller that sits between FPU decode and the shared
// FPU datapath. It accepts one decoded float op at a time. A 32-entry FP
// register scoreboard blocks RAW and WAW hazards. The dynamic rounding mode is
// resolved at acceptance. The op then runs request -> response -> writeback
// handshakes. The controller also tracks FLW loads in flight in the LSU and
// accumulates sticky fflags for the CSR unit.
//
// Ports:
//   clk, rst            core clock, synchronous active-high reset
//   i_*                 decoded op handshake (i_valid/i_ready) and op fields
//   csr_frm             dynamic rounding mode, sampled only at acceptance
//   fpu_req_*           request channel to the datapath
//   fpu_rsp_*           response channel from the datapath (with fflags)
//   wbck_*              writeback request; wbck_illegal marks a bad rm
//   ld_set_*, ld_clr_*  FLW issue / FLW writeback scoreboard updates
//   sb_pend             scoreboard pending bits, exported to the LSU
//   fflags_acc          sticky accumulated exception flags
//   fflags_clr          CSR write that clears the accumulator
//   busy                controller is not idle
module e203_fpu_ctrl #(
    parameter int ITAG_W = 1,
    parameter int NFREG  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    output logic              i_ready,
    input  logic [4:0]        i_ftype,
    input  logic [2:0]        i_rm,
    input  logic              i_frs1en,
    input  logic              i_frs2en,
    input  logic              i_frs3en,
    input  logic              i_frdwen,
    input  logic [4:0]        i_frs1idx,
    input  logic [4:0]        i_frs2idx,
    input  logic [4:0]        i_frs3idx,
    input  logic [4:0]        i_frdidx,
    input  logic              i_rs1fpu,
    input  logic              i_rs2fpu,
    input  logic              i_rs3fpu,
    input  logic              i_rdfpu,
    input  logic [ITAG_W-1:0] i_itag,
    input  logic [2:0]        csr_frm,
    output logic              fpu_req_valid,
    input  logic              fpu_req_ready,
    output logic [4:0]        fpu_req_ftype,
    output logic [2:0]        fpu_req_rm,
    input  logic              fpu_rsp_valid,
    output logic              fpu_rsp_ready,
    input  logic [4:0]        fpu_rsp_fflags,
    output logic              wbck_valid,
    input  logic              wbck_ready,
    output logic              wbck_rdfpu,
    output logic              wbck_rdwen,
    output logic [4:0]        wbck_rdidx,
    output logic [ITAG_W-1:0] wbck_itag,
    output logic              wbck_illegal,
    input  logic              ld_set_valid,
    input  logic [4:0]        ld_set_idx,
    input  logic              ld_clr_valid,
    input  logic [4:0]        ld_clr_idx,
    output logic [NFREG-1:0]  sb_pend,
    output logic [4:0]        fflags_acc,
    input  logic              fflags_clr,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RSP,
        ST_WB
    } state_t;

    state_t              state;
    logic [4:0]          lat_ftype;
    logic [2:0]          lat_rm;
    logic                lat_rdwen;
    logic                lat_rdfpu;
    logic [4:0]          lat_rdidx;
    logic [ITAG_W-1:0]   lat_itag;
    logic                lat_illegal;
    logic [NFREG-1:0]    sb_q;
    logic [NFREG-1:0]    sb_set;
    logic [NFREG-1:0]    sb_clr;
    logic                hazard;
    logic [2:0]          rm_eff;
    logic                rm_illegal;
    logic                accept;
    logic                rsp_fire;
    logic                wb_fire;

    // Integer-file operands and destinations never touch the FP scoreboard.
    assign hazard = (i_frs1en & i_rs1fpu & sb_q[i_frs1idx])
                  | (i_frs2en & i_rs2fpu & sb_q[i_frs2idx])
                  | (i_frs3en & i_rs3fpu & sb_q[i_frs3idx])
                  | (i_frdwen & i_rdfpu  & sb_q[i_frdidx]);

    // rm = 111 selects the dynamic mode; 101/110/111 are reserved encodings.
    assign rm_eff     = (i_rm == 3'b111) ? csr_frm : i_rm;
    assign rm_illegal = rm_eff[2] & (rm_eff[1] | rm_eff[0]);

    assign i_ready  = (state == ST_IDLE) & ~hazard;
    assign accept   = i_valid & i_ready;
    assign rsp_fire = (state == ST_RSP) & fpu_rsp_valid;
    assign wb_fire  = (state == ST_WB) & wbck_ready;

    assign fpu_req_valid = (state == ST_REQ);
    assign fpu_req_ftype = lat_ftype;
    assign fpu_req_rm    = lat_rm;
    assign fpu_rsp_ready = (state == ST_RSP);
    assign wbck_valid    = (state == ST_WB);
    assign wbck_rdfpu    = lat_rdfpu;
    assign wbck_rdwen    = lat_rdwen & ~lat_illegal;
    assign wbck_rdidx    = lat_rdidx;
    assign wbck_itag     = lat_itag;
    assign wbck_illegal  = lat_illegal;
    assign sb_pend       = sb_q;
    assign busy          = (state != ST_IDLE);

    // The writeback clear only applies when this op actually set its bit.
    // Otherwise an integer-destination op could wipe a pending FLW bit with
    // the same index.
    always_comb begin
        sb_set = '0;
        sb_clr = '0;
        if (wb_fire & lat_rdwen & lat_rdfpu & ~lat_illegal) begin
            sb_clr[lat_rdidx] = 1'b1;
        end
        if (ld_clr_valid) begin
            sb_clr[ld_clr_idx] = 1'b1;
        end
        if (accept & i_frdwen & i_rdfpu & ~rm_illegal) begin
            sb_set[i_frdidx] = 1'b1;
        end
        if (ld_set_valid) begin
            sb_set[ld_set_idx] = 1'b1;
        end
    end

    // Clears are applied before sets, so a same-cycle set wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            sb_q <= '0;
        end else begin
            sb_q <= (sb_q & ~sb_clr) | sb_set;
        end
    end

    // A CSR clear in the same cycle as a response keeps only the new flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            fflags_acc <= '0;
        end else if (rsp_fire) begin
            fflags_acc <= (fflags_clr ? 5'd0 : fflags_acc) | fpu_rsp_fflags;
        end else if (fflags_clr) begin
            fflags_acc <= '0;
        end
    end

    // Illegal ops skip the datapath and go straight to writeback. Latched
    // fields only change on acceptance, so they hold while a handshake stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            lat_ftype   <= '0;
            lat_rm      <= '0;
            lat_rdwen   <= 1'b0;
            lat_rdfpu   <= 1'b0;
            lat_rdidx   <= '0;
            lat_itag    <= '0;
            lat_illegal <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        lat_ftype   <= i_ftype;
                        lat_rm      <= rm_eff;
                        lat_rdwen   <= i_frdwen;
                        lat_rdfpu   <= i_rdfpu;
                        lat_rdidx   <= i_frdidx;
                        lat_itag    <= i_itag;
                        lat_illegal <= rm_illegal;
                        state       <= rm_illegal ? ST_WB : ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (fpu_req_ready) begin
                        state <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    if (fpu_rsp_valid) begin
                        state <= ST_WB;
                    end
                end
                ST_WB: begin
                    if (wbck_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
